// File: rtl/ether_pkg.sv
// Shared types and constants for the ether host-side sequencer.
package ether_pkg;

  localparam logic [10:0] MIN_LEN            = 11'd60;
  localparam logic [10:0] MAX_LEN            = 11'd1514;
  localparam logic [19:0] TMO_CYCLES_DEFAULT = 20'd1000000;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_WAIT = 2'd1,
    T_REL  = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_FULL = 2'd1,
    R_REL  = 2'd2
  } rx_state_t;

  // True when a transmit length is a legal frame size.
  function automatic logic len_ok(input logic [10:0] len);
    return (len >= MIN_LEN) && (len <= MAX_LEN);
  endfunction

endpackage

// File: rtl/ether_seq_sync2.sv
// Two-flop synchronizer for single-bit asynchronous handshake inputs.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Shift the asynchronous input through two flops; reset clears both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ether_seq.sv
// Host-side sequencer for the ether MAC: transmit handshake with timeout,
// receive buffer handshake, and deferred loopback configuration.
//
// TX state | meaning
// T_IDLE   | waiting for an acceptable tx_req
// T_WAIT   | txrdy high, waiting for txdone or timeout
// T_REL    | waiting for txdone to drop (four-phase release)
//
// RX state | meaning
// R_IDLE   | waiting for rxrdy with receive enabled
// R_FULL   | frame captured, waiting for host rx_ack
// R_REL    | rxdone high, waiting for rxrdy to drop
module ether_seq
  import ether_pkg::*;
#(
  parameter logic [19:0] TMO_CYCLES = TMO_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_req,
  input  logic [10:0] tx_len,
  output logic        tx_ack,
  output logic        tx_tmo,
  output logic        tx_badlen,
  output logic        txrdy,
  output logic [10:0] txcntb,
  input  logic        txdone,
  input  logic        rxrdy,
  input  logic [10:0] rxcntb,
  input  logic [7:0]  errs,
  output logic        rxdone,
  output logic        rx_avail,
  output logic [10:0] rx_len,
  output logic [7:0]  rx_err,
  input  logic        rx_ack,
  input  logic        cfg_wr,
  input  logic [3:0]  cfg_val,
  output logic [3:0]  lbmode,
  output logic        busy
);

  localparam logic [19:0] TMO_LAST = TMO_CYCLES - 20'd1;

  logic txdone_s;
  logic rxdone_s;

  tx_state_t   r_tx_state, w_tx_state_nxt;
  logic        r_txrdy, w_txrdy_nxt;
  logic [10:0] r_txcntb, w_txcntb_nxt;
  logic [19:0] r_timer, w_timer_nxt;
  logic        r_tx_ack, w_tx_ack_nxt;
  logic        r_tx_tmo, w_tx_tmo_nxt;
  logic        r_tx_badlen, w_tx_badlen_nxt;

  rx_state_t   r_rx_state, w_rx_state_nxt;
  logic        r_rxdone, w_rxdone_nxt;
  logic        r_rx_avail, w_rx_avail_nxt;
  logic [10:0] r_rx_len, w_rx_len_nxt;
  logic [7:0]  r_rx_err, w_rx_err_nxt;

  logic        r_pend, w_pend_nxt;
  logic [3:0]  r_pend_val, w_pend_val_nxt;
  logic [3:0]  r_lbmode, w_lbmode_nxt;
  logic        w_both_idle;

  sync2 u_sync_txdone (
    .clk (clk),
    .rst (rst),
    .i_d (txdone),
    .o_q (txdone_s)
  );

  sync2 u_sync_rxrdy (
    .clk (clk),
    .rst (rst),
    .i_d (rxrdy),
    .o_q (rxdone_s)
  );

  assign w_both_idle = (r_tx_state == T_IDLE) && (r_rx_state == R_IDLE);

  // TX next-state: accept/reject requests, wait for txdone or timeout, release.
  always_comb begin
    w_tx_state_nxt  = r_tx_state;
    w_txrdy_nxt     = r_txrdy;
    w_txcntb_nxt    = r_txcntb;
    w_timer_nxt     = r_timer;
    w_tx_ack_nxt    = 1'b0;
    w_tx_tmo_nxt    = 1'b0;
    w_tx_badlen_nxt = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        // A pending config wins this cycle; the request is taken next cycle.
        if (tx_req && !r_pend && !txdone_s) begin
          if (len_ok(tx_len)) begin
            w_txcntb_nxt   = tx_len;
            w_txrdy_nxt    = 1'b1;
            w_timer_nxt    = 20'd0;
            w_tx_state_nxt = T_WAIT;
          end else begin
            w_tx_badlen_nxt = 1'b1;
          end
        end
      end
      T_WAIT: begin
        // txdone is checked first so a late-but-valid completion is acked.
        if (txdone_s) begin
          w_txrdy_nxt    = 1'b0;
          w_tx_ack_nxt   = 1'b1;
          w_tx_state_nxt = T_REL;
        end else if (r_timer == TMO_LAST) begin
          w_txrdy_nxt    = 1'b0;
          w_tx_tmo_nxt   = 1'b1;
          w_tx_state_nxt = T_REL;
        end else begin
          w_timer_nxt = r_timer + 20'd1;
        end
      end
      T_REL: begin
        if (!txdone_s) w_tx_state_nxt = T_IDLE;
      end
      default: w_tx_state_nxt = T_IDLE;
    endcase
  end

  // RX next-state: capture on rxrdy when enabled, hand to host, release buffer.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rxdone_nxt   = r_rxdone;
    w_rx_avail_nxt = r_rx_avail;
    w_rx_len_nxt   = r_rx_len;
    w_rx_err_nxt   = r_rx_err;
    case (r_rx_state)
      R_IDLE: begin
        // The enable bits only gate starting a capture, never an open handshake.
        if (rxdone_s && (r_lbmode[0] || r_lbmode[1]) && !r_pend) begin
          w_rx_len_nxt   = rxcntb;
          w_rx_err_nxt   = errs;
          w_rx_avail_nxt = 1'b1;
          w_rx_state_nxt = R_FULL;
        end
      end
      R_FULL: begin
        if (rx_ack) begin
          w_rx_avail_nxt = 1'b0;
          w_rxdone_nxt   = 1'b1;
          w_rx_state_nxt = R_REL;
        end
      end
      R_REL: begin
        if (!rxdone_s) begin
          w_rxdone_nxt   = 1'b0;
          w_rx_state_nxt = R_IDLE;
        end
      end
      default: w_rx_state_nxt = R_IDLE;
    endcase
  end

  // Config: hold the last write as pending and apply it once both FSMs are idle.
  always_comb begin
    w_pend_nxt     = r_pend;
    w_pend_val_nxt = r_pend_val;
    w_lbmode_nxt   = r_lbmode;
    if (r_pend && w_both_idle) begin
      w_lbmode_nxt = r_pend_val;
      w_pend_nxt   = 1'b0;
    end
    // A write in the apply cycle stays pending so it is not lost.
    if (cfg_wr) begin
      w_pend_nxt     = 1'b1;
      w_pend_val_nxt = cfg_val;
    end
  end

  // State and output registers; reset clears every output immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state  <= T_IDLE;
      r_txrdy     <= 1'b0;
      r_txcntb    <= 11'd0;
      r_timer     <= 20'd0;
      r_tx_ack    <= 1'b0;
      r_tx_tmo    <= 1'b0;
      r_tx_badlen <= 1'b0;
      r_rx_state  <= R_IDLE;
      r_rxdone    <= 1'b0;
      r_rx_avail  <= 1'b0;
      r_rx_len    <= 11'd0;
      r_rx_err    <= 8'd0;
      r_pend      <= 1'b0;
      r_pend_val  <= 4'd0;
      r_lbmode    <= 4'd0;
    end else begin
      r_tx_state  <= w_tx_state_nxt;
      r_txrdy     <= w_txrdy_nxt;
      r_txcntb    <= w_txcntb_nxt;
      r_timer     <= w_timer_nxt;
      r_tx_ack    <= w_tx_ack_nxt;
      r_tx_tmo    <= w_tx_tmo_nxt;
      r_tx_badlen <= w_tx_badlen_nxt;
      r_rx_state  <= w_rx_state_nxt;
      r_rxdone    <= w_rxdone_nxt;
      r_rx_avail  <= w_rx_avail_nxt;
      r_rx_len    <= w_rx_len_nxt;
      r_rx_err    <= w_rx_err_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_val  <= w_pend_val_nxt;
      r_lbmode    <= w_lbmode_nxt;
    end
  end

  assign tx_ack    = r_tx_ack;
  assign tx_tmo    = r_tx_tmo;
  assign tx_badlen = r_tx_badlen;
  assign txrdy     = r_txrdy;
  assign txcntb    = r_txcntb;
  assign rxdone    = r_rxdone;
  assign rx_avail  = r_rx_avail;
  assign rx_len    = r_rx_len;
  assign rx_err    = r_rx_err;
  assign lbmode    = r_lbmode;
  assign busy      = (r_tx_state != T_IDLE) || (r_rx_state != R_IDLE) || r_pend;

endmodule

// File: tb/tb_ether_seq.sv
// Directed bench for ether_seq. Async inputs change 1 ns after a rising edge,
// so a synchronized event lands on the third rising edge after the change
// (two synchronizer flops plus the FSM output register).
module tb_ether_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_req = 1'b0;
  logic [10:0] tx_len = 11'd0;
  logic        tx_ack, tx_tmo, tx_badlen, txrdy;
  logic [10:0] txcntb;
  logic        txdone = 1'b0;
  logic        rxrdy = 1'b0;
  logic [10:0] rxcntb = 11'd0;
  logic [7:0]  errs = 8'd0;
  logic        rxdone, rx_avail;
  logic [10:0] rx_len;
  logic [7:0]  rx_err;
  logic        rx_ack = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [3:0]  cfg_val = 4'd0;
  logic [3:0]  lbmode;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  ether_seq #(.TMO_CYCLES(20'd16)) dut (
    .clk(clk), .rst(rst), .tx_req(tx_req), .tx_len(tx_len), .tx_ack(tx_ack),
    .tx_tmo(tx_tmo), .tx_badlen(tx_badlen), .txrdy(txrdy), .txcntb(txcntb),
    .txdone(txdone), .rxrdy(rxrdy), .rxcntb(rxcntb), .errs(errs), .rxdone(rxdone),
    .rx_avail(rx_avail), .rx_len(rx_len), .rx_err(rx_err), .rx_ack(rx_ack),
    .cfg_wr(cfg_wr), .cfg_val(cfg_val), .lbmode(lbmode), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if ({tx_ack, tx_tmo, tx_badlen, txrdy, txcntb, rxdone, rx_avail, rx_len, rx_err, lbmode, busy} !== 42'd0) begin
      n_fail++; $display("FAIL reset_outputs: got txrdy=%b lbmode=%h busy=%b, want all 0", txrdy, lbmode, busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_tx_basic();
    int n;
    logic early_ack;
    tx_len = 11'd100; tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    n_tests++;
    if (txrdy !== 1'b1 || txcntb !== 11'd100) begin
      n_fail++; $display("FAIL tx_accept: got txrdy=%b txcntb=%0d, want 1/100", txrdy, txcntb);
    end
    early_ack = 1'b0;
    repeat (9) begin tick(); if (tx_ack !== 1'b0 || txrdy !== 1'b1) early_ack = 1'b1; end
    n_tests++;
    if (early_ack !== 1'b0) begin
      n_fail++; $display("FAIL tx_wait_hold: got unexpected ack or txrdy drop=%b, want 0", early_ack);
    end
    txdone = 1'b1;
    n = 0;
    while (n < 10) begin tick(); n++; if (tx_ack === 1'b1) break; end
    n_tests++;
    if (n !== 3) begin
      n_fail++; $display("FAIL tx_ack_latency: got %0d edges, want 3", n);
    end
    n_tests++;
    if (txrdy !== 1'b0 || txcntb !== 11'd100) begin
      n_fail++; $display("FAIL tx_ack_state: got txrdy=%b txcntb=%0d, want 0/100", txrdy, txcntb);
    end
    tick();
    n_tests++;
    if (tx_ack !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL tx_rel: got tx_ack=%b busy=%b, want 0/1", tx_ack, busy);
    end
    txdone = 1'b0;
    tick(); tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL tx_rel_hold: got busy=%b, want 1", busy);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || txcntb !== 11'd100) begin
      n_fail++; $display("FAIL tx_idle_after: got busy=%b txcntb=%0d, want 0/100", busy, txcntb);
    end
  endtask

  task automatic test_badlen();
    tx_len = 11'd59; tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    n_tests++;
    if (tx_badlen !== 1'b1 || txrdy !== 1'b0 || txcntb !== 11'd100) begin
      n_fail++; $display("FAIL badlen_59: got badlen=%b txrdy=%b txcntb=%0d, want 1/0/100", tx_badlen, txrdy, txcntb);
    end
    tick();
    n_tests++;
    if (tx_badlen !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL badlen_pulse: got badlen=%b busy=%b, want 0/0", tx_badlen, busy);
    end
    tx_len = 11'd1515; tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    n_tests++;
    if (tx_badlen !== 1'b1 || txrdy !== 1'b0) begin
      n_fail++; $display("FAIL badlen_1515: got badlen=%b txrdy=%b, want 1/0", tx_badlen, txrdy);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    logic saw_ack;
    tx_len = 11'd60; tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    n_tests++;
    if (txrdy !== 1'b1 || txcntb !== 11'd60) begin
      n_fail++; $display("FAIL tmo_accept_60: got txrdy=%b txcntb=%0d, want 1/60", txrdy, txcntb);
    end
    n = 0; saw_ack = 1'b0;
    while (n < 40) begin
      tick(); n++;
      if (tx_ack === 1'b1) saw_ack = 1'b1;
      if (tx_tmo === 1'b1) break;
    end
    n_tests++;
    if (n !== 16 || saw_ack !== 1'b0) begin
      n_fail++; $display("FAIL tmo_latency: got %0d edges ack=%b, want 16/0", n, saw_ack);
    end
    n_tests++;
    if (txrdy !== 1'b0) begin
      n_fail++; $display("FAIL tmo_txrdy: got %b, want 0", txrdy);
    end
    tick();
    n_tests++;
    if (tx_tmo !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL tmo_idle: got tmo=%b busy=%b, want 0/0", tx_tmo, busy);
    end
  endtask

  task automatic test_rx();
    int n;
    cfg_val = 4'b0001; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    n_tests++;
    if (lbmode !== 4'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL cfg_pending: got lbmode=%h busy=%b, want 0/1", lbmode, busy);
    end
    tick();
    n_tests++;
    if (lbmode !== 4'b0001 || busy !== 1'b0) begin
      n_fail++; $display("FAIL cfg_apply: got lbmode=%h busy=%b, want 1/0", lbmode, busy);
    end
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    n_tests++;
    if (rxdone !== 1'b0 || rx_avail !== 1'b0) begin
      n_fail++; $display("FAIL rx_ack_idle: got rxdone=%b rx_avail=%b, want 0/0", rxdone, rx_avail);
    end
    rxcntb = 11'd64; errs = 8'h01; rxrdy = 1'b1;
    n = 0;
    while (n < 10) begin tick(); n++; if (rx_avail === 1'b1) break; end
    n_tests++;
    if (n !== 3 || rx_len !== 11'd64 || rx_err !== 8'h01) begin
      n_fail++; $display("FAIL rx_capture: got edges=%0d len=%0d err=%h, want 3/64/01", n, rx_len, rx_err);
    end
    rxcntb = 11'd99; errs = 8'hFF;
    cfg_val = 4'b0000; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    n_tests++;
    if (lbmode !== 4'b0001 || rx_avail !== 1'b1 || rx_len !== 11'd64) begin
      n_fail++; $display("FAIL rx_full_cfg: got lbmode=%h avail=%b len=%0d, want 1/1/64", lbmode, rx_avail, rx_len);
    end
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    n_tests++;
    if (rx_avail !== 1'b0 || rxdone !== 1'b1) begin
      n_fail++; $display("FAIL rx_ack: got avail=%b rxdone=%b, want 0/1", rx_avail, rxdone);
    end
    rxrdy = 1'b0;
    tick(); tick();
    n_tests++;
    if (rxdone !== 1'b1) begin
      n_fail++; $display("FAIL rxdone_hold: got %b, want 1", rxdone);
    end
    tick();
    n_tests++;
    if (rxdone !== 1'b0) begin
      n_fail++; $display("FAIL rxdone_release: got %b, want 0", rxdone);
    end
    tick();
    n_tests++;
    if (lbmode !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rx_cfg_after: got lbmode=%h busy=%b, want 0/0", lbmode, busy);
    end
  endtask

  task automatic test_cfg_during_tx();
    int n;
    tx_len = 11'd1514; tx_req = 1'b1;
    tick();
    n_tests++;
    if (txrdy !== 1'b1 || txcntb !== 11'd1514) begin
      n_fail++; $display("FAIL cfgtx_accept_1514: got txrdy=%b txcntb=%0d, want 1/1514", txrdy, txcntb);
    end
    cfg_val = 4'b0010; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    n_tests++;
    if (lbmode !== 4'd0) begin
      n_fail++; $display("FAIL cfgtx_hold_wait: got lbmode=%h, want 0", lbmode);
    end
    txdone = 1'b1;
    n = 0;
    while (n < 10) begin tick(); n++; if (tx_ack === 1'b1) break; end
    n_tests++;
    if (n !== 3 || lbmode !== 4'd0) begin
      n_fail++; $display("FAIL cfgtx_ack: got edges=%0d lbmode=%h, want 3/0", n, lbmode);
    end
    txdone = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if (lbmode !== 4'd0 || txrdy !== 1'b0) begin
      n_fail++; $display("FAIL cfgtx_first_idle: got lbmode=%h txrdy=%b, want 0/0", lbmode, txrdy);
    end
    tick();
    n_tests++;
    if (lbmode !== 4'b0010 || txrdy !== 1'b0) begin
      n_fail++; $display("FAIL cfgtx_apply: got lbmode=%h txrdy=%b, want 2/0", lbmode, txrdy);
    end
    tick();
    tx_req = 1'b0;
    n_tests++;
    if (txrdy !== 1'b1) begin
      n_fail++; $display("FAIL cfgtx_delayed_req: got txrdy=%b, want 1", txrdy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    rxcntb = 11'd200; errs = 8'h80; rxrdy = 1'b1;
    n = 0;
    while (n < 10) begin tick(); n++; if (rx_avail === 1'b1) break; end
    n_tests++;
    if (n !== 3 || rx_len !== 11'd200 || txrdy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_setup: got edges=%0d len=%0d txrdy=%b, want 3/200/1", n, rx_len, txrdy);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({tx_ack, tx_tmo, tx_badlen, txrdy, txcntb, rxdone, rx_avail, rx_len, rx_err, lbmode, busy} !== 42'd0) begin
      n_fail++; $display("FAIL rstmid_async: got txrdy=%b avail=%b lbmode=%h busy=%b, want all 0", txrdy, rx_avail, lbmode, busy);
    end
    tick();
    rst = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (rx_avail !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_rx_disabled: got avail=%b busy=%b, want 0/0", rx_avail, busy);
    end
    tx_len = 11'd80; tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    n_tests++;
    if (txrdy !== 1'b1 || txcntb !== 11'd80) begin
      n_fail++; $display("FAIL rstmid_tx_restart: got txrdy=%b txcntb=%0d, want 1/80", txrdy, txcntb);
    end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_badlen();
    test_timeout();
    test_rx();
    test_cfg_during_tx();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
